// File: rtl/inst_sequencer_pkg.sv
// Shared types for the 16-bit core instruction sequencer: register ids, ALU ops,
// sequencer states, the IR1 word layout and fetch-length helpers.
package inst_sequencer_pkg;

  typedef enum logic [3:0] {
    R_ZR   = 4'd0,
    R_IR1  = 4'd1,
    R_IR2  = 4'd2,
    R_IR3  = 4'd3,
    R_IP   = 4'd4,
    R_REGA = 4'd5,
    R_REGB = 4'd6,
    R_REGC = 4'd7,
    R_REGD = 4'd8,
    R_REGE = 4'd9,
    R_SP   = 4'd10,
    R_ADDR = 4'd11,
    R_MEM  = 4'd12,
    R_FLAG = 4'd13
  } reg_id_e;

  typedef enum logic [5:0] {
    ALU_MOV = 6'h00,
    ALU_INC = 6'h01,
    ALU_DEC = 6'h02,
    ALU_NOT = 6'h03,
    ALU_AND = 6'h08,
    ALU_OR  = 6'h09,
    ALU_ADD = 6'h0A,
    ALU_SUB = 6'h0B
  } alu_op_e;

  typedef enum logic [3:0] {
    IF1   = 4'd0,
    D1    = 4'd1,
    IF2   = 4'd2,
    D2    = 4'd3,
    IF3   = 4'd4,
    D3    = 4'd5,
    EXE   = 4'd6,
    EXEA  = 4'd7,
    RD    = 4'd8,
    WR    = 4'd9,
    PUSH1 = 4'd10,
    PUSH2 = 4'd11,
    POP1  = 4'd12,
    POP2  = 4'd13
  } inst_state_e;

  typedef enum logic [1:0] {
    CLS_ALU   = 2'd0,
    CLS_LOAD  = 2'd1,
    CLS_STORE = 2'd2,
    CLS_STACK = 2'd3
  } insn_cls_e;

  typedef struct packed {
    alu_op_e   op;
    insn_cls_e cls;
    reg_id_e   dst;
    reg_id_e   src;
  } insn1_t;

  function automatic logic needs_ir3(input insn1_t i);
    return (i.dst == R_IR3) || (i.src == R_IR3);
  endfunction

  function automatic logic needs_ir2(input insn1_t i);
    return (i.dst == R_IR2) || (i.src == R_IR2) || needs_ir3(i);
  endfunction

  function automatic logic is_mem_state(input inst_state_e s);
    return (s == IF1) || (s == IF2) || (s == IF3) || (s == RD) ||
           (s == WR) || (s == PUSH2) || (s == POP1);
  endfunction

  // First state of the class-specific tail once all fetch words are in.
  function automatic inst_state_e class_state(input insn1_t i);
    case (i.cls)
      CLS_ALU:             return EXE;
      CLS_LOAD, CLS_STORE: return EXEA;
      CLS_STACK:           return i.op[0] ? PUSH1 : POP1;
      default:             return IF1;
    endcase
  endfunction

endpackage

// File: rtl/inst_sequencer_mem_wait_timer.sv
// Counts consecutive un-acknowledged memory-state cycles and flags the cycle in
// which the wait limit is reached. A WAIT_MAX of 0 never expires.
module inst_sequencer_mem_wait_timer #(
  parameter int unsigned WAIT_MAX = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ack,
  input  logic leave,
  output logic expired
);

  localparam int unsigned CW     = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam int unsigned LAST_I = (WAIT_MAX > 0) ? WAIT_MAX - 1 : 0;
  localparam logic [CW-1:0] LAST = CW'(LAST_I);
  localparam logic ENABLE = (WAIT_MAX > 0) ? 1'b1 : 1'b0;

  logic [CW-1:0] count_r;

  // Expiry is the WAIT_MAX-th un-acked cycle; an ack in that cycle wins.
  assign expired = ENABLE && active && !ack && (count_r == LAST);

  // Wait counter: restarts on ack, on leaving the state, or after expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (!active || ack || leave || expired) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/inst_sequencer.sv
// Main control FSM of the 16-bit core: fetches IR1..IR3 over a req/ack memory
// port and sequences ALU, load, store, push and pop datapath controls.
module inst_sequencer
  import inst_sequencer_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_addr_sel,
  output logic [5:0]  alu_op,
  output logic [3:0]  sel_a,
  output logic [3:0]  sel_b,
  output logic [3:0]  sel_dst,
  output logic        reg_we,
  output logic        flag_we,
  output logic [3:0]  state,
  output logic        insn_done,
  output logic        bus_err
);

  inst_state_e state_r, state_nom_s, state_next_s;
  insn1_t      ir1_r;
  logic        expired_s, leave_s;

  logic    req_s, we_s, rwe_s, fwe_s, done_s;
  reg_id_e addr_s, a_s, b_s, dst_s;
  alu_op_e op_s;

  logic    req_o, we_o, rwe_o, fwe_o, done_o, berr_o;
  reg_id_e addr_o, a_o, b_o, dst_o;
  alu_op_e op_o;

  inst_sequencer_mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_mem_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .active  (is_mem_state(state_r)),
    .ack     (mem_ack),
    .leave   (leave_s),
    .expired (expired_s)
  );

  assign leave_s = (state_nom_s != state_r);

  // Per-state controls and nominal next state, before timeout and reset override.
  always_comb begin
    state_nom_s = state_r;
    req_s  = 1'b0;
    we_s   = 1'b0;
    rwe_s  = 1'b0;
    fwe_s  = 1'b0;
    done_s = 1'b0;
    addr_s = R_IP;
    op_s   = ALU_MOV;
    a_s    = R_ZR;
    b_s    = R_ZR;
    dst_s  = R_ZR;
    case (state_r)
      IF1, IF2, IF3: begin
        req_s = 1'b1;
        a_s   = R_MEM;
        dst_s = (state_r == IF1) ? R_IR1 : ((state_r == IF2) ? R_IR2 : R_IR3);
        rwe_s = mem_ack;
        if (mem_ack) begin
          state_nom_s = (state_r == IF1) ? D1 : ((state_r == IF2) ? D2 : D3);
        end else begin
          state_nom_s = state_r;
        end
      end
      D1, D2, D3: begin
        op_s  = ALU_INC;
        a_s   = R_IP;
        dst_s = R_IP;
        rwe_s = 1'b1;
        if ((state_r == D1) && needs_ir2(ir1_r)) begin
          state_nom_s = IF2;
        end else if ((state_r == D2) && needs_ir3(ir1_r)) begin
          state_nom_s = IF3;
        end else begin
          state_nom_s = class_state(ir1_r);
        end
      end
      EXE: begin
        op_s   = ir1_r.op;
        a_s    = ir1_r.dst;
        b_s    = ir1_r.src;
        dst_s  = ir1_r.dst;
        rwe_s  = 1'b1;
        fwe_s  = 1'b1;
        done_s = 1'b1;
        state_nom_s = IF1;
      end
      EXEA: begin
        a_s   = (ir1_r.cls == CLS_LOAD) ? ir1_r.src : ir1_r.dst;
        dst_s = R_ADDR;
        rwe_s = 1'b1;
        state_nom_s = (ir1_r.cls == CLS_LOAD) ? RD : WR;
      end
      RD, POP1: begin
        req_s  = 1'b1;
        addr_s = (state_r == RD) ? R_ADDR : R_SP;
        a_s    = R_MEM;
        dst_s  = ir1_r.dst;
        rwe_s  = mem_ack;
        done_s = mem_ack && (state_r == RD);
        if (mem_ack) begin
          state_nom_s = (state_r == RD) ? IF1 : POP2;
        end else begin
          state_nom_s = state_r;
        end
      end
      WR, PUSH2: begin
        req_s  = 1'b1;
        we_s   = 1'b1;
        addr_s = (state_r == WR) ? R_ADDR : R_SP;
        a_s    = ir1_r.src;
        done_s = mem_ack;
        if (mem_ack) begin
          state_nom_s = IF1;
        end else begin
          state_nom_s = state_r;
        end
      end
      PUSH1: begin
        op_s  = ALU_DEC;
        a_s   = R_SP;
        dst_s = R_SP;
        rwe_s = 1'b1;
        state_nom_s = PUSH2;
      end
      POP2: begin
        op_s   = ALU_INC;
        a_s    = R_SP;
        dst_s  = R_SP;
        rwe_s  = 1'b1;
        done_s = 1'b1;
        state_nom_s = IF1;
      end
      default: begin
        state_nom_s = IF1;
      end
    endcase
  end

  // Reset forces defaults; a wait timeout aborts the instruction back to IF1.
  always_comb begin
    state_next_s = state_nom_s;
    req_o  = req_s;
    we_o   = we_s;
    rwe_o  = rwe_s;
    fwe_o  = fwe_s;
    done_o = done_s;
    berr_o = 1'b0;
    addr_o = addr_s;
    op_o   = op_s;
    a_o    = a_s;
    b_o    = b_s;
    dst_o  = dst_s;
    if (rst) begin
      state_next_s = IF1;
      req_o  = 1'b0;
      we_o   = 1'b0;
      rwe_o  = 1'b0;
      fwe_o  = 1'b0;
      done_o = 1'b0;
      addr_o = R_IP;
      op_o   = ALU_MOV;
      a_o    = R_ZR;
      b_o    = R_ZR;
      dst_o  = R_ZR;
    end else if (expired_s) begin
      state_next_s = IF1;
      berr_o = 1'b1;
      rwe_o  = 1'b0;
      done_o = 1'b0;
    end else begin
      state_next_s = state_nom_s;
    end
  end

  // State register and IR1 capture on the IF1 acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IF1;
      ir1_r   <= '0;
    end else begin
      state_r <= state_next_s;
      if ((state_r == IF1) && mem_ack) begin
        ir1_r <= insn1_t'(mem_rdata);
      end else begin
        ir1_r <= ir1_r;
      end
    end
  end

  assign mem_req      = req_o;
  assign mem_we       = we_o;
  assign mem_addr_sel = addr_o;
  assign alu_op       = op_o;
  assign sel_a        = a_o;
  assign sel_b        = b_o;
  assign sel_dst      = dst_o;
  assign reg_we       = rwe_o;
  assign flag_we      = fwe_o;
  assign state        = state_r;
  assign insn_done    = done_o;
  assign bus_err      = berr_o;

endmodule

// File: tb/tb_inst_sequencer.sv
// Randomized self-checking bench: expected per-cycle controls are generated from
// the instruction word and the chosen ack delays, independent of the RTL.
module tb_inst_sequencer;
  import inst_sequencer_pkg::*;

  localparam int WAIT_MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, reg_we, flag_we, insn_done, bus_err;
  logic [3:0]  mem_addr_sel, sel_a, sel_b, sel_dst, state;
  logic [5:0]  alu_op;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       req;
    logic       we;
    logic [3:0] addr;
    logic [5:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] dst;
    logic       rwe;
    logic       fwe;
    logic       done;
    logic       berr;
  } exp_t;

  inst_sequencer #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .alu_op(alu_op), .sel_a(sel_a), .sel_b(sel_b), .sel_dst(sel_dst),
    .reg_we(reg_we), .flag_we(flag_we), .state(state),
    .insn_done(insn_done), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic exp_t dflt(input logic [3:0] st);
    exp_t e;
    e = '0;
    e.st = st;
    e.addr = R_IP;
    e.op = ALU_MOV;
    e.a = R_ZR;
    e.b = R_ZR;
    e.dst = R_ZR;
    return e;
  endfunction

  // Apply inputs mid-cycle, let combinational outputs settle, compare.
  task automatic step(input string tag, input exp_t e, input logic ack,
                      input logic [15:0] rd, input logic r);
    exp_t o;
    @(negedge clk);
    rst = r;
    mem_ack = ack;
    mem_rdata = rd;
    #1;
    o = {state, mem_req, mem_we, mem_addr_sel, alu_op, sel_a, sel_b, sel_dst,
         reg_we, flag_we, insn_done, bus_err};
    check_val(tag, o, e);
  endtask

  // Memory access: delay wait cycles then ack; with tmo no ack and a timeout.
  task automatic mem_phase(input string tag, input logic [3:0] st, input logic [3:0] addr,
                           input logic we, input logic [3:0] a, input logic [3:0] dst,
                           input logic wr_reg, input logic last, input int delay,
                           input logic [15:0] rd, input logic tmo);
    exp_t e;
    int   n;
    logic ack;
    n = tmo ? WAIT_MAX : delay + 1;
    for (int k = 0; k < n; k++) begin
      ack = !tmo && (k == n - 1);
      e = dflt(st);
      e.req = 1'b1;
      e.we = we;
      e.addr = addr;
      e.a = a;
      e.dst = dst;
      e.rwe = wr_reg && ack;
      e.done = last && ack;
      e.berr = tmo && (k == n - 1);
      step(tag, e, ack, ack ? rd : 16'($urandom), 1'b0);
    end
  endtask

  task automatic one_phase(input string tag, input logic [3:0] st, input logic [5:0] op,
                           input logic [3:0] a, input logic [3:0] b, input logic [3:0] dst,
                           input logic rwe, input logic fwe, input logic done);
    exp_t e;
    e = dflt(st);
    e.op = op;
    e.a = a;
    e.b = b;
    e.dst = dst;
    e.rwe = rwe;
    e.fwe = fwe;
    e.done = done;
    step(tag, e, 1'b0, 16'($urandom), 1'b0);
  endtask

  // Whole instruction from the IR1 word; tmo times out the class memory access.
  task automatic run_insn(input logic [15:0] ir, input int d_if, input int d_mem, input logic tmo);
    logic [5:0] op;
    logic [1:0] cls;
    logic [3:0] dst, src;
    logic       n2, n3;
    op = ir[15:10];
    cls = ir[9:8];
    dst = ir[7:4];
    src = ir[3:0];
    n3 = (dst == R_IR3) || (src == R_IR3);
    n2 = n3 || (dst == R_IR2) || (src == R_IR2);
    mem_phase("IF1", IF1, R_IP, 1'b0, R_MEM, R_IR1, 1'b1, 1'b0, d_if, ir, 1'b0);
    one_phase("D1", D1, ALU_INC, R_IP, R_ZR, R_IP, 1'b1, 1'b0, 1'b0);
    if (n2) begin
      mem_phase("IF2", IF2, R_IP, 1'b0, R_MEM, R_IR2, 1'b1, 1'b0, $urandom_range(0, 3), 16'h0000, 1'b0);
      one_phase("D2", D2, ALU_INC, R_IP, R_ZR, R_IP, 1'b1, 1'b0, 1'b0);
    end
    if (n3) begin
      mem_phase("IF3", IF3, R_IP, 1'b0, R_MEM, R_IR3, 1'b1, 1'b0, $urandom_range(0, 3), 16'h0000, 1'b0);
      one_phase("D3", D3, ALU_INC, R_IP, R_ZR, R_IP, 1'b1, 1'b0, 1'b0);
    end
    case (cls)
      2'd0: one_phase("EXE", EXE, op, dst, src, dst, 1'b1, 1'b1, 1'b1);
      2'd1: begin
        one_phase("EXEA_ld", EXEA, ALU_MOV, src, R_ZR, R_ADDR, 1'b1, 1'b0, 1'b0);
        mem_phase("RD", RD, R_ADDR, 1'b0, R_MEM, dst, 1'b1, 1'b1, d_mem, 16'h0000, tmo);
      end
      2'd2: begin
        one_phase("EXEA_st", EXEA, ALU_MOV, dst, R_ZR, R_ADDR, 1'b1, 1'b0, 1'b0);
        mem_phase("WR", WR, R_ADDR, 1'b1, src, R_ZR, 1'b0, 1'b1, d_mem, 16'h0000, tmo);
      end
      default: begin
        if (op[0]) begin
          one_phase("PUSH1", PUSH1, ALU_DEC, R_SP, R_ZR, R_SP, 1'b1, 1'b0, 1'b0);
          mem_phase("PUSH2", PUSH2, R_SP, 1'b1, src, R_ZR, 1'b0, 1'b1, d_mem, 16'h0000, tmo);
        end else begin
          mem_phase("POP1", POP1, R_SP, 1'b0, R_MEM, dst, 1'b1, 1'b0, d_mem, 16'h0000, tmo);
          if (!tmo) one_phase("POP2", POP2, ALU_INC, R_SP, R_ZR, R_SP, 1'b1, 1'b0, 1'b1);
        end
      end
    endcase
  endtask

  initial begin
    logic [15:0] ir;
    exp_t        e;

    step("reset", dflt(IF1), 1'b0, 16'h0000, 1'b1);
    step("reset_hold", dflt(IF1), 1'b1, 16'hFFFF, 1'b1);

    run_insn(16'h2856, 0, 0, 1'b0);
    run_insn(16'h2853, 0, 0, 1'b0);
    run_insn(16'h0178, 1, 3, 1'b0);
    run_insn(16'h0709, 0, 2, 1'b0);
    run_insn(16'h02A5, 2, 1, 1'b0);
    run_insn(16'h0360, 0, 3, 1'b0);

    // IF1 timeout, then a fetch acked in the last allowed cycle.
    mem_phase("IF1_tmo", IF1, R_IP, 1'b0, R_MEM, R_IR1, 1'b1, 1'b0, 0, 16'h0000, 1'b1);
    run_insn(16'h2856, WAIT_MAX - 1, 0, 1'b0);
    run_insn(16'h0178, 0, 0, 1'b1);
    run_insn(16'h0709, 0, 0, 1'b1);
    run_insn(16'h0360, 0, 0, 1'b1);

    // Reset in the middle of an RD wait.
    mem_phase("IF1", IF1, R_IP, 1'b0, R_MEM, R_IR1, 1'b1, 1'b0, 0, 16'h0178, 1'b0);
    one_phase("D1", D1, ALU_INC, R_IP, R_ZR, R_IP, 1'b1, 1'b0, 1'b0);
    one_phase("EXEA_ld", EXEA, ALU_MOV, R_REGD, R_ZR, R_ADDR, 1'b1, 1'b0, 1'b0);
    e = dflt(RD);
    e.req = 1'b1;
    e.addr = R_ADDR;
    e.a = R_MEM;
    e.dst = R_REGC;
    step("RD_wait", e, 1'b0, 16'h0000, 1'b0);
    step("RD_rst", dflt(RD), 1'b0, 16'h0000, 1'b1);
    run_insn(16'h2856, 0, 0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      ir = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ir[3:0] = 4'($urandom_range(2, 3));
      if ($urandom_range(0, 5) == 0) ir[7:4] = 4'($urandom_range(2, 3));
      run_insn(ir, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
